gnn_seq_ctrl: RTL and testbench
===============================

Name: gnn_seq_ctrl

Overview:
- Sequencer for the two-layer GNN datapath: aggregation 1 -> four dnn_layer1 node MACs -> aggregation 2 -> relu_4n.
- Takes a start request, issues one-cycle go pulses to each stage in order, and waits for each stage's ready.
- Collects the four per-node MAC readies, guards every wait with a timeout, and reports busy/done/error and per-node output-ready flags.
- Sits beside the datapath top; drives its in_ready-style inputs and consumes its ready outputs.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for any single stage ready before error.
- TO_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.
- LAT_W, 12, width of the end-to-end latency counter (saturating).
- NUM_NODES, 4, number of graph nodes, equal to the number of MAC ready inputs.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one inference; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- aggr1_ready  in  1  first aggregation result valid.
- mac_ready  in  NUM_NODES  per-node dnn_layer1 ready; bits may rise in different cycles.
- aggr2_ready  in  1  second aggregation result valid.
- relu_ready  in  1  ReLU outputs valid.
- aggr1_go  out  1  one-cycle launch pulse to aggregation 1.
- mac_go  out  1  one-cycle launch pulse to all node MACs.
- aggr2_go  out  1  one-cycle launch pulse to aggregation 2.
- relu_go  out  1  one-cycle launch pulse to ReLU.
- busy  out  1  high from the cycle after start is accepted until DONE/ERR/abort.
- done  out  1  one-cycle pulse when the result is complete.
- err_timeout  out  1  sticky; set on timeout, cleared on the next accepted start or on rst.
- err_stage  out  3  state code that timed out; valid while err_timeout=1.
- out_ready  out  2*NUM_NODES  {out11,out10} per node; all set with done, held until next accepted start/rst/abort.
- lat_count  out  LAT_W  cycles from start acceptance to done; saturates at all-ones, held until next start.
- state  out  3  current FSM state code, for debug.

Behaviour:
- Reset values: every output is 0; state=IDLE; counters and the MAC mask are 0.
- States and codes: IDLE=0, A1=1, MAC=2, A2=3, RL=4, DONE=5, ERR=6.
- IDLE: start=1 -> A1 next cycle. Accepting start clears err_timeout, out_ready, lat_count and the MAC mask.
- Each go pulse is registered and asserts for exactly the first cycle in its wait state (A1: aggr1_go, MAC: mac_go, A2: aggr2_go, RL: relu_go).
- Ready inputs are sampled from the cycle after the go pulse onward. A ready present during the go cycle is ignored, to avoid stale readies from the previous run.
- A1: aggr1_ready=1 -> MAC.
- MAC: mask |= mac_ready each sampled cycle; when (mask | mac_ready) is all ones -> A2. The mask clears on leaving MAC.
- A2: aggr2_ready=1 -> A2 exits to RL.
- RL: relu_ready=1 -> DONE.
- DONE: lasts one cycle. done=1, out_ready set to all ones, busy=0 from this cycle, then IDLE.
- Timeout: the counter resets on entering each wait state and increments every cycle without the required ready.
  - When the counter reaches TIMEOUT_CYCLES and ready is still absent -> ERR. err_timeout=1 and err_stage=state code.
  - ERR lasts one cycle, then IDLE. done is not pulsed and out_ready stays 0.
- A ready arriving in the same cycle the counter hits TIMEOUT_CYCLES takes priority: normal transition, no error.
- start while busy (not IDLE) is ignored; it is not queued.
- abort has priority over every other transition. Next state is IDLE; no go pulses; busy=0; out_ready=0; err_timeout is unchanged.
- abort and start together in IDLE: abort wins and start is dropped.
- rst mid-operation: all state and outputs return to reset values on the next edge.
- lat_count: 0 on the accept cycle, +1 each cycle while busy, saturating. Minimum latency: start at cycle 0 with all readies arriving the cycle after their go gives done at cycle 9 and lat_count=8.

Decomposition:
- Shared package gnn_ctrl_pkg holds the state encoding constants (IDLE..ERR) and the default TIMEOUT_CYCLES.
- One natural sub-module, gnn_stage_timer: load/clear on stage entry, increment, expire flag. The FSM instantiates it once and reuses it across stages.

Test Plan:
- Nominal: start at cycle 0, each ready driven the cycle after its go -> go pulses at cycles 1, 3, 5, 7; done at cycle 9; lat_count=8; out_ready=8'hFF.
- Staggered MAC: mac_ready bits pulse singly at +1, +4, +2, +7 cycles after mac_go -> A2 is entered the cycle after the last bit; aggr2_go fires exactly once.
- Timeout: TIMEOUT_CYCLES=10, aggr2_ready never asserted -> err_timeout=1, err_stage=3, no done, out_ready=0; a following start clears err_timeout.
- Boundary: aggr1_ready arrives exactly on the cycle the counter reaches 10 -> no error; MAC is entered.
- Abort/stale: abort in MAC -> IDLE next cycle, busy=0, no further go pulses. Separately, start held high during a run plus a ready asserted during its go cycle -> no second run and no early advance.
- rst asserted during RL -> all outputs 0 on the next edge; a new start then completes normally.

Source files
------------

// File: rtl/gnn_ctrl_pkg.sv
// Shared encodings for the GNN sequencer: FSM state codes and default timeout.
package gnn_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A1   = 3'd1;
  localparam logic [2:0] ST_MAC  = 3'd2;
  localparam logic [2:0] ST_A2   = 3'd3;
  localparam logic [2:0] ST_RL   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Wait states are the ones that launch a stage and wait for its ready.
  function automatic logic is_wait_state(input logic [2:0] s);
    return (s >= ST_A1) && (s <= ST_RL);
  endfunction

endpackage

// File: rtl/gnn_seq_ctrl_if.sv
// Control/status bundle between the GNN sequencer (master) and the datapath side (slave).
interface gnn_seq_ctrl_if #(
  parameter int NUM_NODES = 4,
  parameter int LAT_W     = 12
);

  logic                   start;
  logic                   abort;
  logic                   aggr1_ready;
  logic [NUM_NODES-1:0]   mac_ready;
  logic                   aggr2_ready;
  logic                   relu_ready;
  logic                   aggr1_go;
  logic                   mac_go;
  logic                   aggr2_go;
  logic                   relu_go;
  logic                   busy;
  logic                   done;
  logic                   err_timeout;
  logic [2:0]             err_stage;
  logic [2*NUM_NODES-1:0] out_ready;
  logic [LAT_W-1:0]       lat_count;
  logic [2:0]             state;

  modport master (
    input  start, abort, aggr1_ready, mac_ready, aggr2_ready, relu_ready,
    output aggr1_go, mac_go, aggr2_go, relu_go, busy, done,
           err_timeout, err_stage, out_ready, lat_count, state
  );

  modport slave (
    output start, abort, aggr1_ready, mac_ready, aggr2_ready, relu_ready,
    input  aggr1_go, mac_go, aggr2_go, relu_go, busy, done,
           err_timeout, err_stage, out_ready, lat_count, state
  );

endinterface

// File: rtl/gnn_stage_timer.sv
// Per-stage wait timer: cleared on stage entry, counts cycles without ready, flags expiry.
module gnn_stage_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic            expired_o,
  output logic [TO_W-1:0] count_o
);

  logic [TO_W-1:0] count_q;

  assign expired_o = (count_q == TO_W'(TIMEOUT_CYCLES));
  assign count_o   = count_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
    end else if (inc_i && !expired_o) begin
      count_q <= count_q + TO_W'(1);
    end
  end

endmodule

// File: rtl/gnn_seq_ctrl.sv
// Two-layer GNN sequencer: A1 -> node MACs -> A2 -> ReLU, one go pulse per stage, per-stage timeout.
module gnn_seq_ctrl
  import gnn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TO_W           = 8,
  parameter int LAT_W          = 12,
  parameter int NUM_NODES      = 4
) (
  input  logic          clk,
  input  logic          rst,
  gnn_seq_ctrl_if.master bus
);

  logic [2:0]             state_q, state_d;
  logic                   aggr1_go_q, mac_go_q, aggr2_go_q, relu_go_q;
  logic [NUM_NODES-1:0]   mask_q;
  logic                   err_timeout_q;
  logic [2:0]             err_stage_q;
  logic [2*NUM_NODES-1:0] out_ready_q;
  logic [LAT_W-1:0]       lat_q;

  logic            enter;
  logic            sample_en;
  logic            stage_ready;
  logic            accept;
  logic            busy;
  logic            to_expired;
  logic [TO_W-1:0] to_count;

  // Readies seen during a go cycle may be left over from the previous run.
  assign sample_en = !(aggr1_go_q | mac_go_q | aggr2_go_q | relu_go_q);
  assign accept    = (state_q == ST_IDLE) && bus.start && !bus.abort;
  assign busy      = is_wait_state(state_q);
  assign enter     = (state_d != state_q);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    stage_ready = 1'b0;
    state_d     = state_q;
    unique case (state_q)
      ST_A1:   stage_ready = bus.aggr1_ready;
      ST_MAC:  stage_ready = &(mask_q | bus.mac_ready);
      ST_A2:   stage_ready = bus.aggr2_ready;
      ST_RL:   stage_ready = bus.relu_ready;
      default: stage_ready = 1'b0;
    endcase

    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_A1;
      ST_A1, ST_MAC, ST_A2, ST_RL: begin
        if (sample_en && stage_ready) begin
          unique case (state_q)
            ST_A1:   state_d = ST_MAC;
            ST_MAC:  state_d = ST_A2;
            ST_A2:   state_d = ST_RL;
            default: state_d = ST_DONE;
          endcase
        end else if (to_expired) begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.abort) state_d = ST_IDLE;
  end

  gnn_stage_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (enter),
    .inc_i     (busy),
    .expired_o (to_expired),
    .count_o   (to_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      aggr1_go_q    <= 1'b0;
      mac_go_q      <= 1'b0;
      aggr2_go_q    <= 1'b0;
      relu_go_q     <= 1'b0;
      mask_q        <= '0;
      err_timeout_q <= 1'b0;
      err_stage_q   <= '0;
      out_ready_q   <= '0;
      lat_q         <= '0;
    end else begin
      state_q    <= state_d;
      aggr1_go_q <= enter && (state_d == ST_A1);
      mac_go_q   <= enter && (state_d == ST_MAC);
      aggr2_go_q <= enter && (state_d == ST_A2);
      relu_go_q  <= enter && (state_d == ST_RL);

      mask_q <= (state_q == ST_MAC && state_d == ST_MAC && sample_en)
                ? (mask_q | bus.mac_ready) : '0;

      if (accept) begin
        err_timeout_q <= 1'b0;
        err_stage_q   <= '0;
      end else if (state_d == ST_ERR) begin
        err_timeout_q <= 1'b1;
        err_stage_q   <= state_q;
      end

      if (bus.abort || accept) begin
        out_ready_q <= '0;
      end else if (state_d == ST_DONE) begin
        out_ready_q <= '1;
      end

      if (accept) begin
        lat_q <= '0;
      end else if (busy && lat_q != '1) begin
        lat_q <= lat_q + LAT_W'(1);
      end
    end
  end

  assign bus.aggr1_go    = aggr1_go_q;
  assign bus.mac_go      = mac_go_q;
  assign bus.aggr2_go    = aggr2_go_q;
  assign bus.relu_go     = relu_go_q;
  assign bus.busy        = busy;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_stage   = err_stage_q;
  assign bus.out_ready   = out_ready_q;
  assign bus.lat_count   = lat_q;
  assign bus.state       = state_q;

  logic unused_ok;
  assign unused_ok = ^to_count;

endmodule

// File: tb/tb_gnn_seq_ctrl.sv
// Directed bench for gnn_seq_ctrl: cycle table for nominal/stale runs, hand sequences for corner cases.
module tb_gnn_seq_ctrl;
  import gnn_ctrl_pkg::*;

  localparam int NN = 4;
  localparam int LW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   a1_cnt, mac_cnt, a2_cnt, rl_cnt, done_cnt;

  gnn_seq_ctrl_if #(.NUM_NODES(NN), .LAT_W(LW)) bus ();

  gnn_seq_ctrl #(
    .TIMEOUT_CYCLES (10),
    .TO_W           (8),
    .LAT_W          (LW),
    .NUM_NODES      (NN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       start, a1r;
    logic [3:0] mac;
    logic       a2r, rlr;
    logic [2:0] st;
    logic [3:0] go;
    logic       busy, done;
    logic [7:0] ordy;
    logic [11:0] lat;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(input logic s, a, input logic [3:0] m, input logic b, r,
                              input logic [2:0] st, input logic [3:0] go, input logic bz, d,
                              input logic [7:0] o, input logic [11:0] l);
    vec_t v;
    v.start = s; v.a1r = a; v.mac = m; v.a2r = b; v.rlr = r;
    v.st = st; v.go = go; v.busy = bz; v.done = d; v.ordy = o; v.lat = l;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.aggr1_go) a1_cnt++;
    if (bus.mac_go)   mac_cnt++;
    if (bus.aggr2_go) a2_cnt++;
    if (bus.relu_go)  rl_cnt++;
    if (bus.done)     done_cnt++;
  endtask

  task automatic clr_cnt();
    a1_cnt = 0; mac_cnt = 0; a2_cnt = 0; rl_cnt = 0; done_cnt = 0;
  endtask

  task automatic clear_ready();
    bus.aggr1_ready = 1'b0;
    bus.mac_ready   = '0;
    bus.aggr2_ready = 1'b0;
    bus.relu_ready  = 1'b0;
  endtask

  // Stimulus responder: answer each stage one cycle after its go.
  task automatic auto_ready();
    bus.aggr1_ready = (bus.state == ST_A1) && !bus.aggr1_go;
    bus.mac_ready   = {NN{(bus.state == ST_MAC) && !bus.mac_go}};
    bus.aggr2_ready = (bus.state == ST_A2) && !bus.aggr2_go;
    bus.relu_ready  = (bus.state == ST_RL) && !bus.relu_go;
  endtask

  task automatic goto_state(input logic [2:0] target, input string name);
    int n;
    n = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (bus.state != target && n < 30) begin
      auto_ready();
      tick();
      clear_ready();
      n++;
    end
    check({name, "_reach"}, 32'(bus.state), 32'(target));
  endtask

  task automatic run_nominal(input string name);
    int n;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      auto_ready();
      tick();
      clear_ready();
      n++;
    end
    check({name, "_done_cycle"}, 32'(n), 32'd9);
    check({name, "_lat"}, 32'(bus.lat_count), 32'd8);
    check({name, "_out_ready"}, 32'(bus.out_ready), 32'hFF);
    check({name, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clear_ready();
    clr_cnt();

    // Cycles 0-10: nominal run; 10-23: start held high, stale readies in go cycles.
    tbl[0]  = mk(1,0,4'h0,0,0, ST_IDLE,4'b0000,0,0,8'h00,12'd0);
    tbl[1]  = mk(0,0,4'h0,0,0, ST_A1,  4'b1000,1,0,8'h00,12'd0);
    tbl[2]  = mk(0,1,4'h0,0,0, ST_A1,  4'b0000,1,0,8'h00,12'd1);
    tbl[3]  = mk(0,0,4'h0,0,0, ST_MAC, 4'b0100,1,0,8'h00,12'd2);
    tbl[4]  = mk(0,0,4'hF,0,0, ST_MAC, 4'b0000,1,0,8'h00,12'd3);
    tbl[5]  = mk(0,0,4'h0,0,0, ST_A2,  4'b0010,1,0,8'h00,12'd4);
    tbl[6]  = mk(0,0,4'h0,1,0, ST_A2,  4'b0000,1,0,8'h00,12'd5);
    tbl[7]  = mk(0,0,4'h0,0,0, ST_RL,  4'b0001,1,0,8'h00,12'd6);
    tbl[8]  = mk(0,0,4'h0,0,1, ST_RL,  4'b0000,1,0,8'h00,12'd7);
    tbl[9]  = mk(0,0,4'h0,0,0, ST_DONE,4'b0000,0,1,8'hFF,12'd8);
    tbl[10] = mk(1,0,4'h0,0,0, ST_IDLE,4'b0000,0,0,8'hFF,12'd8);
    tbl[11] = mk(1,1,4'h0,0,0, ST_A1,  4'b1000,1,0,8'h00,12'd0);
    tbl[12] = mk(1,0,4'h0,0,0, ST_A1,  4'b0000,1,0,8'h00,12'd1);
    tbl[13] = mk(1,1,4'h0,0,0, ST_A1,  4'b0000,1,0,8'h00,12'd2);
    tbl[14] = mk(1,0,4'hF,0,0, ST_MAC, 4'b0100,1,0,8'h00,12'd3);
    tbl[15] = mk(1,0,4'h0,0,0, ST_MAC, 4'b0000,1,0,8'h00,12'd4);
    tbl[16] = mk(1,0,4'hF,0,0, ST_MAC, 4'b0000,1,0,8'h00,12'd5);
    tbl[17] = mk(1,0,4'h0,1,0, ST_A2,  4'b0010,1,0,8'h00,12'd6);
    tbl[18] = mk(1,0,4'h0,1,0, ST_A2,  4'b0000,1,0,8'h00,12'd7);
    tbl[19] = mk(1,0,4'h0,0,1, ST_RL,  4'b0001,1,0,8'h00,12'd8);
    tbl[20] = mk(1,0,4'h0,0,1, ST_RL,  4'b0000,1,0,8'h00,12'd9);
    tbl[21] = mk(0,0,4'h0,0,0, ST_DONE,4'b0000,0,1,8'hFF,12'd10);
    tbl[22] = mk(0,0,4'h0,0,0, ST_IDLE,4'b0000,0,0,8'hFF,12'd10);
    tbl[23] = mk(0,0,4'h0,0,0, ST_IDLE,4'b0000,0,0,8'hFF,12'd10);

    tick();
    tick();
    rst = 1'b0;
    check("reset_err_stage", 32'(bus.err_stage), 32'd0);

    for (int i = 0; i < 24; i++) begin
      bus.start       = tbl[i].start;
      bus.aggr1_ready = tbl[i].a1r;
      bus.mac_ready   = tbl[i].mac;
      bus.aggr2_ready = tbl[i].a2r;
      bus.relu_ready  = tbl[i].rlr;
      check($sformatf("row%0d_state", i), 32'(bus.state), 32'(tbl[i].st));
      check($sformatf("row%0d_go", i),
            32'({bus.aggr1_go, bus.mac_go, bus.aggr2_go, bus.relu_go}), 32'(tbl[i].go));
      check($sformatf("row%0d_busy_done", i), 32'({bus.busy, bus.done}),
            32'({tbl[i].busy, tbl[i].done}));
      check($sformatf("row%0d_out_ready", i), 32'(bus.out_ready), 32'(tbl[i].ordy));
      check($sformatf("row%0d_lat", i), 32'(bus.lat_count), 32'(tbl[i].lat));
      check($sformatf("row%0d_err", i), 32'(bus.err_timeout), 32'd0);
      tick();
    end
    bus.start = 1'b0;
    clear_ready();

    // Staggered MAC readies: bits at +1, +4, +2, +7 after mac_go.
    clr_cnt();
    goto_state(ST_MAC, "stag");
    check("stag_mac_go", 32'(bus.mac_go), 32'd1);
    for (int off = 1; off <= 7; off++) begin
      tick();
      bus.mac_ready = (off == 1) ? 4'b0001 : (off == 2) ? 4'b0100 :
                      (off == 4) ? 4'b0010 : (off == 7) ? 4'b1000 : 4'b0000;
      if (off == 7) check("stag_still_mac", 32'(bus.state), 32'(ST_MAC));
    end
    tick();
    bus.mac_ready = '0;
    check("stag_a2_state", 32'(bus.state), 32'(ST_A2));
    check("stag_a2_go", 32'(bus.aggr2_go), 32'd1);
    for (int n = 0; n < 20 && !bus.done; n++) begin
      auto_ready();
      tick();
      clear_ready();
    end
    check("stag_a2_go_count", 32'(a2_cnt), 32'd1);
    check("stag_done_count", 32'(done_cnt), 32'd1);
    tick();

    // Timeout in A2.
    clr_cnt();
    goto_state(ST_A2, "to");
    repeat (10) tick();
    check("to_last_wait", 32'(bus.state), 32'(ST_A2));
    tick();
    check("to_err_state", 32'(bus.state), 32'(ST_ERR));
    check("to_err_timeout", 32'(bus.err_timeout), 32'd1);
    check("to_err_stage", 32'(bus.err_stage), 32'(ST_A2));
    check("to_out_ready", 32'(bus.out_ready), 32'd0);
    check("to_busy", 32'(bus.busy), 32'd0);
    tick();
    check("to_idle", 32'(bus.state), 32'(ST_IDLE));
    check("to_sticky", 32'(bus.err_timeout), 32'd1);
    check("to_no_done", 32'(done_cnt), 32'd0);

    // Boundary: aggr1_ready exactly when the counter reaches 10; start clears the error.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bd_err_cleared", 32'(bus.err_timeout), 32'd0);
    repeat (10) tick();
    check("bd_still_a1", 32'(bus.state), 32'(ST_A1));
    bus.aggr1_ready = 1'b1;
    tick();
    bus.aggr1_ready = 1'b0;
    check("bd_mac_state", 32'(bus.state), 32'(ST_MAC));
    check("bd_no_err", 32'(bus.err_timeout), 32'd0);

    // Abort in MAC.
    tick();
    clr_cnt();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab_idle", 32'(bus.state), 32'(ST_IDLE));
    check("ab_busy", 32'(bus.busy), 32'd0);
    bus.mac_ready   = '1;
    bus.aggr2_ready = 1'b1;
    repeat (5) tick();
    clear_ready();
    check("ab_no_go", 32'(a1_cnt + mac_cnt + a2_cnt + rl_cnt), 32'd0);

    // abort and start together in IDLE.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abst_idle", 32'(bus.state), 32'(ST_IDLE));
    check("abst_no_go", 32'(a1_cnt), 32'd0);

    // rst during RL, then a clean run.
    goto_state(ST_RL, "rs");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_state", 32'(bus.state), 32'(ST_IDLE));
    check("rs_go", 32'({bus.aggr1_go, bus.mac_go, bus.aggr2_go, bus.relu_go}), 32'd0);
    check("rs_busy_done", 32'({bus.busy, bus.done}), 32'd0);
    check("rs_lat", 32'(bus.lat_count), 32'd0);
    check("rs_out_err", 32'({bus.out_ready, bus.err_timeout, bus.err_stage}), 32'd0);
    run_nominal("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
